barycentre_tracker: RTL and testbench



---
 rtl/bary_pkg.sv | 27 ++
 rtl/udiv_seq.sv | 76 +++++++
 rtl/barycentre_tracker.sv | 183 ++++++++++++++++++
 tb/tb_barycentre_tracker.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/bary_pkg.sv
// ============================================================================
// Module      : bary_pkg
// Description : Shared widths, FSM state type and pixel type for the tracker.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package bary_pkg;
    localparam int CNT_W   = 19;
    localparam int SUM_W   = 28;
    localparam int COORD_W = 9;

    typedef enum logic [1:0] {
        ACCUM   = 2'd0,
        DIV_X   = 2'd1,
        DIV_Y   = 2'd2,
        PUBLISH = 2'd3
    } bary_state_t;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb_t;
endpackage

`default_nettype wire

// File: rtl/udiv_seq.sv
// ============================================================================
// Module      : udiv_seq
// Description : Restoring shift-subtract unsigned divider, one load cycle
//               plus DW iterations; start is only accepted while idle.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module udiv_seq #(
    parameter int DW = 28,
    parameter int VW = 19,
    parameter int QW = 9
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_start,
    input  logic [DW-1:0] i_dividend,
    input  logic [VW-1:0] i_divisor,
    output logic          o_busy,
    output logic          o_done,
    output logic [QW-1:0] o_quotient
);
    localparam int CW = $clog2(DW + 1);

    logic [VW-1:0] r_rem;
    logic [VW-1:0] r_div;
    logic [DW-1:0] r_quo;
    logic [CW-1:0] r_iter;
    logic          r_busy;
    logic          r_done;

    logic [VW:0]   w_shift;
    logic [VW-1:0] w_diff;
    logic          w_ge;

    // Partial remainder stays below the divisor, so VW bits plus the shifted-in bit suffice.
    assign w_shift = {r_rem, r_quo[DW-1]};
    assign w_ge    = w_shift >= {1'b0, r_div};
    assign w_diff  = w_shift[VW-1:0] - r_div;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rem  <= '0;
            r_div  <= '0;
            r_quo  <= '0;
            r_iter <= '0;
            r_busy <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (!r_busy) begin
                if (i_start) begin
                    r_rem  <= '0;
                    r_div  <= i_divisor;
                    r_quo  <= i_dividend;
                    r_iter <= CW'(DW);
                    r_busy <= 1'b1;
                end
            end else begin
                r_rem  <= w_ge ? w_diff : w_shift[VW-1:0];
                r_quo  <= {r_quo[DW-2:0], w_ge};
                r_iter <= r_iter - CW'(1);
                if (r_iter == CW'(1)) begin
                    r_busy <= 1'b0;
                    r_done <= 1'b1;
                end
            end
        end
    end

    assign o_busy     = r_busy;
    assign o_done     = r_done;
    assign o_quotient = r_quo[QW-1:0];
endmodule

`default_nettype wire

// File: rtl/barycentre_tracker.sv
// ============================================================================
// Module      : barycentre_tracker
// Description : Per-frame centroid of thresholded pixels, crosshair overlay
//               and exported barycentre for the tracking logic.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module barycentre_tracker
    import bary_pkg::*;
#(
    parameter int          THRESH      = 128,
    parameter int          MIN_PIXELS  = 16,
    parameter int          CROSS_HALF  = 8,
    parameter logic [23:0] CROSS_COLOR = 24'hFF0000
) (
    input  logic               VGA_CLK,
    input  logic               reset,
    input  logic               IMG,
    input  logic               VGA_VS,
    input  logic [COORD_W-1:0] X_Cont,
    input  logic [COORD_W-1:0] Y_Cont,
    input  logic [7:0]         r,
    input  logic [7:0]         g,
    input  logic [7:0]         b,
    output logic [7:0]         r_out,
    output logic [7:0]         g_out,
    output logic [7:0]         b_out,
    output logic [COORD_W-1:0] BARY_X,
    output logic [COORD_W-1:0] BARY_Y,
    output logic               BARY_VALID,
    output logic [CNT_W-1:0]   PIX_COUNT,
    output logic               FRAME_DROP
);
    localparam logic [7:0]       c_thresh = 8'(THRESH);
    localparam logic [CNT_W-1:0] c_min    = CNT_W'(MIN_PIXELS);
    localparam logic signed [9:0] c_half  = 10'(CROSS_HALF);

    bary_state_t        r_state, w_next;
    logic               r_vs_d;
    logic [CNT_W-1:0]   r_cnt, r_snap_cnt, r_pix_count;
    logic [SUM_W-1:0]   r_sum_x, r_sum_y, r_snap_sum_y;
    logic [COORD_W-1:0] r_qx, r_qy, r_bary_x, r_bary_y;
    logic               r_valid, r_drop;
    rgb_t               r_pix;

    logic               w_hit, w_frame_end;
    logic [SUM_W-1:0]   w_x_ext, w_y_ext;
    logic               w_div_start, w_div_busy, w_div_done;
    logic [SUM_W-1:0]   w_div_dividend;
    logic [CNT_W-1:0]   w_div_divisor;
    logic [COORD_W-1:0] w_quot;

    assign w_hit       = IMG && (g >= c_thresh);
    assign w_frame_end = VGA_VS && !r_vs_d;
    assign w_x_ext     = {{(SUM_W-COORD_W){1'b0}}, X_Cont};
    assign w_y_ext     = {{(SUM_W-COORD_W){1'b0}}, Y_Cont};

    always_ff @(posedge VGA_CLK or posedge reset) begin
        if (reset) r_state <= ACCUM;
        else       r_state <= w_next;
    end

    // X division is launched straight from the live accumulators in the frame-end cycle.
    always_comb begin
        w_next         = r_state;
        w_div_start    = 1'b0;
        w_div_dividend = r_sum_x;
        w_div_divisor  = r_cnt;
        case (r_state)
            ACCUM: begin
                if (w_frame_end) begin
                    if (r_cnt >= c_min) begin
                        w_div_start = !w_div_busy;
                        w_next      = DIV_X;
                    end else begin
                        w_next = PUBLISH;
                    end
                end
            end
            DIV_X: begin
                w_div_dividend = r_snap_sum_y;
                w_div_divisor  = r_snap_cnt;
                if (w_div_done) begin
                    w_div_start = !w_div_busy;
                    w_next      = DIV_Y;
                end
            end
            DIV_Y: begin
                if (w_div_done) w_next = PUBLISH;
            end
            PUBLISH: w_next = ACCUM;
            default: w_next = ACCUM;
        endcase
    end

    udiv_seq #(
        .DW (SUM_W),
        .VW (CNT_W),
        .QW (COORD_W)
    ) u_div (
        .clk        (VGA_CLK),
        .rst        (reset),
        .i_start    (w_div_start),
        .i_dividend (w_div_dividend),
        .i_divisor  (w_div_divisor),
        .o_busy     (w_div_busy),
        .o_done     (w_div_done),
        .o_quotient (w_quot)
    );

    always_ff @(posedge VGA_CLK or posedge reset) begin
        if (reset) begin
            r_vs_d       <= 1'b0;
            r_cnt        <= '0;
            r_sum_x      <= '0;
            r_sum_y      <= '0;
            r_snap_cnt   <= '0;
            r_snap_sum_y <= '0;
            r_qx         <= '0;
            r_qy         <= '0;
            r_pix_count  <= '0;
            r_valid      <= 1'b0;
            r_bary_x     <= '0;
            r_bary_y     <= '0;
            r_drop       <= 1'b0;
        end else begin
            r_vs_d <= VGA_VS;
            if (w_frame_end) begin
                r_cnt   <= {{(CNT_W-1){1'b0}}, w_hit};
                r_sum_x <= w_hit ? w_x_ext : '0;
                r_sum_y <= w_hit ? w_y_ext : '0;
                if (r_state == ACCUM) begin
                    r_snap_cnt   <= r_cnt;
                    r_snap_sum_y <= r_sum_y;
                end
                if (r_state == DIV_X || r_state == DIV_Y) r_drop <= 1'b1;
            end else if (w_hit) begin
                r_cnt   <= r_cnt + CNT_W'(1);
                r_sum_x <= r_sum_x + w_x_ext;
                r_sum_y <= r_sum_y + w_y_ext;
            end
            if (r_state == DIV_X && w_div_done) r_qx <= w_quot;
            if (r_state == DIV_Y && w_div_done) r_qy <= w_quot;
            if (r_state == PUBLISH) begin
                r_pix_count <= r_snap_cnt;
                r_valid     <= (r_snap_cnt >= c_min);
                if (r_snap_cnt >= c_min) begin
                    r_bary_x <= r_qx;
                    r_bary_y <= r_qy;
                end
            end
        end
    end

    // Signed 10-bit distances let the arms clip at the borders instead of wrapping.
    logic signed [9:0] w_dx, w_dy;
    logic              w_cross;
    rgb_t              w_pix_in;

    assign w_dx     = $signed({1'b0, X_Cont}) - $signed({1'b0, r_bary_x});
    assign w_dy     = $signed({1'b0, Y_Cont}) - $signed({1'b0, r_bary_y});
    assign w_cross  = r_valid && IMG &&
                      (((Y_Cont == r_bary_y) && (w_dx >= -c_half) && (w_dx <= c_half)) ||
                       ((X_Cont == r_bary_x) && (w_dy >= -c_half) && (w_dy <= c_half)));
    assign w_pix_in = {r, g, b};

    always_ff @(posedge VGA_CLK or posedge reset) begin
        if (reset) r_pix <= '0;
        else       r_pix <= w_cross ? rgb_t'(CROSS_COLOR) : w_pix_in;
    end

    assign r_out      = r_pix.r;
    assign g_out      = r_pix.g;
    assign b_out      = r_pix.b;
    assign BARY_X     = r_bary_x;
    assign BARY_Y     = r_bary_y;
    assign BARY_VALID = r_valid;
    assign PIX_COUNT  = r_pix_count;
    assign FRAME_DROP = r_drop;
endmodule

`default_nettype wire

// File: tb/tb_barycentre_tracker.sv
// ============================================================================
// Module      : tb_barycentre_tracker
// Description : Drives two trackers (MIN_PIXELS 16 and 1) with directed and
//               random frames and compares against a frame-level model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_barycentre_tracker;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       img = 1'b0, vs = 1'b0;
    logic [8:0] x = '0, y = '0;
    logic [7:0] pr = '0, pg = '0, pb = '0;

    logic [7:0]  ro [2];
    logic [7:0]  go [2];
    logic [7:0]  bo [2];
    logic [8:0]  bx [2];
    logic [8:0]  by [2];
    logic        bv [2];
    logic [18:0] pc [2];
    logic        fd [2];

    barycentre_tracker u_dut16 (
        .VGA_CLK(clk), .reset(reset), .IMG(img), .VGA_VS(vs), .X_Cont(x), .Y_Cont(y),
        .r(pr), .g(pg), .b(pb), .r_out(ro[0]), .g_out(go[0]), .b_out(bo[0]),
        .BARY_X(bx[0]), .BARY_Y(by[0]), .BARY_VALID(bv[0]), .PIX_COUNT(pc[0]),
        .FRAME_DROP(fd[0])
    );

    barycentre_tracker #(.MIN_PIXELS(1)) u_dut1 (
        .VGA_CLK(clk), .reset(reset), .IMG(img), .VGA_VS(vs), .X_Cont(x), .Y_Cont(y),
        .r(pr), .g(pg), .b(pb), .r_out(ro[1]), .g_out(go[1]), .b_out(bo[1]),
        .BARY_X(bx[1]), .BARY_Y(by[1]), .BARY_VALID(bv[1]), .PIX_COUNT(pc[1]),
        .FRAME_DROP(fd[1])
    );

    always #20 clk = ~clk;

    int n_vec = 0, n_fail = 0;

    // Frame-level reference: running totals, snapshot at VS rise, published results.
    int     m_min [2] = '{16, 1};
    int     m_cnt = 0, s_cnt = 0;
    longint m_sx = 0, m_sy = 0, s_sx = 0, s_sy = 0;
    bit     m_vs_prev = 1'b0;
    int     e_pc [2] = '{0, 0};
    int     e_bx [2] = '{0, 0};
    int     e_by [2] = '{0, 0};
    bit     e_v  [2] = '{1'b0, 1'b0};
    bit     e_fd [2] = '{1'b0, 1'b0};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic bit is_cross(input int k, input int xx, input int yy, input bit im);
        int dx, dy;
        if (!e_v[k] || !im) return 1'b0;
        dx = xx - e_bx[k];
        dy = yy - e_by[k];
        return (yy == e_by[k] && dx >= -8 && dx <= 8) || (xx == e_bx[k] && dy >= -8 && dy <= 8);
    endfunction

    task automatic apply(input bit im, input int xx, input int yy, input int gv, input bit v);
        logic [7:0]  rr, bb;
        logic [23:0] exp_px [2];
        rr = 8'($urandom);
        bb = 8'($urandom);
        if (v && !m_vs_prev) begin
            s_cnt = m_cnt; s_sx = m_sx; s_sy = m_sy;
            m_cnt = 0; m_sx = 0; m_sy = 0;
        end
        m_vs_prev = v;
        if (im && gv >= 128) begin
            m_cnt++; m_sx += xx; m_sy += yy;
        end
        for (int k = 0; k < 2; k++)
            exp_px[k] = is_cross(k, xx, yy, im) ? 24'hFF0000 : {rr, 8'(gv), bb};
        img = im; x = 9'(xx); y = 9'(yy); pr = rr; pg = 8'(gv); pb = bb; vs = v;
        tick();
        for (int k = 0; k < 2; k++)
            check(k == 0 ? "pixel/m16" : "pixel/m1", {ro[k], go[k], bo[k]}, exp_px[k]);
    endtask

    task automatic check_results(input string tag);
        for (int k = 0; k < 2; k++) begin
            check({tag, k == 0 ? "/m16" : "/m1", " count"}, 32'(pc[k]), e_pc[k]);
            check({tag, k == 0 ? "/m16" : "/m1", " valid"}, 32'(bv[k]), 32'(e_v[k]));
            check({tag, k == 0 ? "/m16" : "/m1", " bary_x"}, 32'(bx[k]), e_bx[k]);
            check({tag, k == 0 ? "/m16" : "/m1", " bary_y"}, 32'(by[k]), e_by[k]);
            check({tag, k == 0 ? "/m16" : "/m1", " drop"}, 32'(fd[k]), 32'(e_fd[k]));
        end
    endtask

    // One VS pulse, blanking long enough for both divisions; optional second pulse at drop_at.
    task automatic end_frame(input string tag, input int drop_at, input bit lat);
        int     c;
        longint sx, sy;
        apply(1'b0, 0, 0, 0, 1'b1);
        c = s_cnt; sx = s_sx; sy = s_sy;
        for (int i = 1; i < 70; i++) begin
            apply(1'b0, 0, 0, 0, i == drop_at);
            if (lat && i == 58) check({tag, " latency early"}, 32'(pc[1]), e_pc[1]);
            if (lat && i == 59) check({tag, " latency publish"}, 32'(pc[1]), c);
        end
        for (int k = 0; k < 2; k++) begin
            e_pc[k] = c;
            e_v[k]  = (c >= m_min[k]);
            if (e_v[k]) begin
                e_bx[k] = int'(sx / c);
                e_by[k] = int'(sy / c);
            end
            if (drop_at > 0) e_fd[k] = 1'b1;
        end
        check_results(tag);
    endtask

    task automatic random_pixels(input int n, input bit force_on);
        for (int i = 0; i < n; i++)
            apply(force_on ? 1'b1 : ($urandom_range(0, 3) != 0), $urandom_range(0, 511),
                  $urandom_range(0, 479), force_on ? 255 : $urandom_range(0, 255), 1'b0);
    endtask

    initial begin
        repeat (3) tick();
        check_results("reset");
        for (int k = 0; k < 2; k++)
            check("reset pixel", {ro[k], go[k], bo[k]}, 24'h0);
        reset = 1'b0;
        repeat (2) tick();

        // Single on-pixel among dark, off-area and just-below-threshold pixels
        for (int i = 0; i < 20; i++)
            apply(1'b1, $urandom_range(0, 511), $urandom_range(0, 479), $urandom_range(0, 127), 1'b0);
        apply(1'b0, 10, 10, 255, 1'b0);
        apply(1'b1, 60, 70, 127, 1'b0);
        apply(1'b1, 100, 50, 255, 1'b0);
        end_frame("single", 0, 1'b1);

        for (int yy = 300; yy < 310; yy++)
            for (int xx = 200; xx < 210; xx++)
                apply(1'b1, xx, yy, 255, 1'b0);
        end_frame("square", 0, 1'b0);

        // Crosshair at (204,304) on the frame following the square
        for (int xx = 190; xx < 216; xx++) apply(1'b1, xx, 304, $urandom_range(0, 255), 1'b0);
        for (int yy = 290; yy < 316; yy++) apply(1'b1, 204, yy, $urandom_range(0, 255), 1'b0);
        apply(1'b0, 204, 304, 10, 1'b0);
        end_frame("overlay", 0, 1'b0);

        apply(1'b1, 0, 0, 255, 1'b0);
        apply(1'b1, 511, 511, 255, 1'b0);
        end_frame("corners", 0, 1'b0);

        for (int i = 0; i < 20; i++)
            apply(i[0], $urandom_range(0, 511), $urandom_range(0, 479), i[0] ? 127 : 255, 1'b0);
        end_frame("none", 0, 1'b0);

        for (int yy = 2; yy < 6; yy++)
            for (int xx = 2; xx < 6; xx++)
                apply(1'b1, xx, yy, 255, 1'b0);
        end_frame("near_origin", 0, 1'b0);

        // Arms near (3,3) must clip rather than wrap to the far edge
        for (int xx = 0; xx < 16; xx++)   apply(1'b1, xx, 3, $urandom_range(0, 255), 1'b0);
        for (int xx = 500; xx < 512; xx++) apply(1'b1, xx, 3, $urandom_range(0, 255), 1'b0);
        for (int yy = 0; yy < 16; yy++)   apply(1'b1, 3, yy, $urandom_range(0, 255), 1'b0);
        for (int yy = 500; yy < 512; yy++) apply(1'b1, 3, yy, $urandom_range(0, 255), 1'b0);
        end_frame("clip", 0, 1'b0);

        for (int f = 0; f < 4; f++) begin
            random_pixels(150, 1'b0);
            end_frame("random", 0, 1'b0);
        end

        random_pixels(40, 1'b1);
        end_frame("drop", 35, 1'b0);

        // Asynchronous reset ten cycles into the X division
        random_pixels(30, 1'b1);
        apply(1'b0, 0, 0, 0, 1'b1);
        for (int i = 0; i < 10; i++) apply(1'b0, 0, 0, 0, 1'b0);
        #5 reset = 1'b1;
        #1;
        m_cnt = 0; m_sx = 0; m_sy = 0; m_vs_prev = 1'b0;
        for (int k = 0; k < 2; k++) begin
            e_pc[k] = 0; e_bx[k] = 0; e_by[k] = 0; e_v[k] = 1'b0; e_fd[k] = 1'b0;
            check("async reset pixel", {ro[k], go[k], bo[k]}, 24'h0);
        end
        check_results("async_reset");
        repeat (3) tick();
        reset = 1'b0;
        repeat (2) tick();

        random_pixels(30, 1'b1);
        end_frame("post_reset", 0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end
endmodule

`default_nettype wire
